// File: rtl/alu_ctrl_decode_pkg.sv
// Shared definitions for the ID-stage ALU control decoder: opcode map,
// sub-op and B-select encodings, and the packed ID/EX control bundle.
package alu_ctrl_decode_pkg;

  localparam int CTRL_DW = 16;
  localparam int CTRL_RW = 3;

  localparam logic [4:0] OP_HALT    = 5'b00000;
  localparam logic [4:0] OP_NOP     = 5'b00001;
  localparam logic [4:0] OP_SIIC    = 5'b00010;
  localparam logic [4:0] OP_RTI     = 5'b00011;
  localparam logic [4:0] OP_J       = 5'b00100;
  localparam logic [4:0] OP_JR      = 5'b00101;
  localparam logic [4:0] OP_JAL     = 5'b00110;
  localparam logic [4:0] OP_JALR    = 5'b00111;
  localparam logic [4:0] OP_ADDI    = 5'b01000;
  localparam logic [4:0] OP_SUBI    = 5'b01001;
  localparam logic [4:0] OP_XORI    = 5'b01010;
  localparam logic [4:0] OP_ANDNI   = 5'b01011;
  localparam logic [4:0] OP_BEQZ    = 5'b01100;
  localparam logic [4:0] OP_BNEZ    = 5'b01101;
  localparam logic [4:0] OP_BLTZ    = 5'b01110;
  localparam logic [4:0] OP_BGEZ    = 5'b01111;
  localparam logic [4:0] OP_ST      = 5'b10000;
  localparam logic [4:0] OP_LD      = 5'b10001;
  localparam logic [4:0] OP_SLBI    = 5'b10010;
  localparam logic [4:0] OP_STU     = 5'b10011;
  localparam logic [4:0] OP_ROLI    = 5'b10100;
  localparam logic [4:0] OP_SLLI    = 5'b10101;
  localparam logic [4:0] OP_RORI    = 5'b10110;
  localparam logic [4:0] OP_SRLI    = 5'b10111;
  localparam logic [4:0] OP_LBI     = 5'b11000;
  localparam logic [4:0] OP_BTR     = 5'b11001;
  localparam logic [4:0] OP_SHIFT_R = 5'b11010;
  localparam logic [4:0] OP_ARITH_R = 5'b11011;
  localparam logic [4:0] OP_SEQ     = 5'b11100;
  localparam logic [4:0] OP_SLT     = 5'b11101;
  localparam logic [4:0] OP_SLE     = 5'b11110;
  localparam logic [4:0] OP_SCO     = 5'b11111;

  localparam logic [1:0] SUB_ADD  = 2'b00;
  localparam logic [1:0] SUB_SUB  = 2'b01;
  localparam logic [1:0] SUB_XOR  = 2'b10;
  localparam logic [1:0] SUB_ANDN = 2'b11;

  localparam logic [1:0] BSEL_RT   = 2'b00;
  localparam logic [1:0] BSEL_IMM  = 2'b01;
  localparam logic [1:0] BSEL_ZERO = 2'b10;

  typedef struct packed {
    logic [4:0]         alu_op;
    logic [1:0]         sub_op;
    logic               inv_a;
    logic               inv_b;
    logic               cin;
    logic [1:0]         b_sel;
    logic [CTRL_DW-1:0] imm;
    logic [CTRL_RW-1:0] rs;
    logic [CTRL_RW-1:0] rt;
    logic               wr_en;
    logic [CTRL_RW-1:0] wr_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{alu_op: OP_NOP, default: '0};

  function automatic logic [CTRL_DW-1:0] sext5(input logic [4:0] v);
    return {{(CTRL_DW-5){v[4]}}, v};
  endfunction

  function automatic logic [CTRL_DW-1:0] sext8(input logic [7:0] v);
    return {{(CTRL_DW-8){v[7]}}, v};
  endfunction

  function automatic logic [CTRL_DW-1:0] sext11(input logic [10:0] v);
    return {{(CTRL_DW-11){v[10]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_instr_field_decode.sv
// Purely combinational instruction -> ALU control bundle decoder.
module instr_field_decode
  import alu_ctrl_decode_pkg::*;
#(
  parameter logic [CTRL_RW-1:0] LINK_REG = 3'd7
) (
  input  logic [CTRL_DW-1:0] instr,
  output ctrl_t              ctrl
);

  logic [4:0] op;
  assign op = instr[15:11];

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = op;
    ctrl.rs     = instr[10:8];
    ctrl.rt     = instr[7:5];
    ctrl.b_sel  = BSEL_IMM;
    ctrl.wr_en  = 1'b1;
    if (op == OP_SHIFT_R || op == OP_ARITH_R)
      ctrl.sub_op = instr[1:0];

    unique case (op)
      OP_HALT, OP_NOP, OP_SIIC, OP_RTI: ctrl.wr_en = 1'b0;
      OP_J: begin
        ctrl.imm   = sext11(instr[10:0]);
        ctrl.wr_en = 1'b0;
      end
      OP_JR: begin
        ctrl.imm   = sext8(instr[7:0]);
        ctrl.wr_en = 1'b0;
      end
      OP_JAL: begin
        ctrl.imm    = sext11(instr[10:0]);
        ctrl.wr_reg = LINK_REG;
      end
      OP_JALR: begin
        ctrl.imm    = sext8(instr[7:0]);
        ctrl.wr_reg = LINK_REG;
      end
      OP_ADDI, OP_LD: begin
        ctrl.imm    = sext5(instr[4:0]);
        ctrl.wr_reg = instr[7:5];
      end
      // Subtract is computed as ~A + B + 1 in the shared adder.
      OP_SUBI: begin
        ctrl.imm    = sext5(instr[4:0]);
        ctrl.wr_reg = instr[7:5];
        ctrl.inv_a  = 1'b1;
        ctrl.cin    = 1'b1;
      end
      OP_XORI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        ctrl.imm    = {{(CTRL_DW-5){1'b0}}, instr[4:0]};
        ctrl.wr_reg = instr[7:5];
      end
      OP_ANDNI: begin
        ctrl.imm    = {{(CTRL_DW-5){1'b0}}, instr[4:0]};
        ctrl.wr_reg = instr[7:5];
        ctrl.inv_b  = 1'b1;
      end
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
        ctrl.imm   = sext8(instr[7:0]);
        ctrl.b_sel = BSEL_ZERO;
        ctrl.wr_en = 1'b0;
      end
      OP_ST: begin
        ctrl.imm   = sext5(instr[4:0]);
        ctrl.wr_en = 1'b0;
      end
      OP_STU: begin
        ctrl.imm    = sext5(instr[4:0]);
        ctrl.wr_reg = instr[10:8];
      end
      OP_SLBI: begin
        ctrl.imm    = {{(CTRL_DW-8){1'b0}}, instr[7:0]};
        ctrl.wr_reg = instr[10:8];
      end
      OP_LBI: begin
        ctrl.imm    = sext8(instr[7:0]);
        ctrl.wr_reg = instr[10:8];
      end
      OP_BTR: begin
        ctrl.b_sel  = BSEL_ZERO;
        ctrl.wr_reg = instr[4:2];
      end
      OP_SHIFT_R, OP_SCO: begin
        ctrl.b_sel  = BSEL_RT;
        ctrl.wr_reg = instr[4:2];
      end
      OP_ARITH_R: begin
        ctrl.b_sel  = BSEL_RT;
        ctrl.wr_reg = instr[4:2];
        ctrl.inv_a  = (instr[1:0] == SUB_SUB);
        ctrl.cin    = (instr[1:0] == SUB_SUB);
        ctrl.inv_b  = (instr[1:0] == SUB_ANDN);
      end
      // Compares evaluate A - B as A + ~B + 1.
      OP_SEQ, OP_SLT, OP_SLE: begin
        ctrl.b_sel  = BSEL_RT;
        ctrl.wr_reg = instr[4:2];
        ctrl.inv_b  = 1'b1;
        ctrl.cin    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// ID/EX pipeline register around the ALU control decoder, with a
// valid/ready handshake, flush squashing and a sticky HALT state.
module alu_ctrl_decode
  import alu_ctrl_decode_pkg::*;
#(
  parameter int DW       = 16,
  parameter int RW       = 3,
  parameter int LINK_REG = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] instr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    alu_op,
  output logic [1:0]    sub_op,
  output logic          inv_a,
  output logic          inv_b,
  output logic          cin,
  output logic [1:0]    b_sel,
  output logic [DW-1:0] imm,
  output logic [RW-1:0] rs,
  output logic [RW-1:0] rt,
  output logic          wr_en,
  output logic [RW-1:0] wr_reg,
  output logic          exc,
  output logic          halted
);

  ctrl_t dec;
  ctrl_t ctrl_q;
  logic  accept;
  logic  is_halt;
  logic  is_siic;

  instr_field_decode #(
    .LINK_REG(3'(LINK_REG))
  ) u_decode (
    .instr(instr),
    .ctrl (dec)
  );

  assign in_ready = ~halted & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_halt  = (instr[15:11] == OP_HALT);
  assign is_siic  = (instr[15:11] == OP_SIIC);

  // Flush beats accept and stall; a squashed or drained slot also drops
  // wr_en so a bubble never looks like a writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      halted    <= 1'b0;
      exc       <= 1'b0;
      ctrl_q    <= CTRL_RESET;
    end else begin
      exc <= accept & ~flush & is_siic;
      if (flush) begin
        out_valid    <= 1'b0;
        ctrl_q.wr_en <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        ctrl_q    <= dec;
        if (is_halt)
          halted <= 1'b1;
      end else if (out_ready) begin
        out_valid    <= 1'b0;
        ctrl_q.wr_en <= 1'b0;
      end
    end
  end

  assign alu_op = ctrl_q.alu_op;
  assign sub_op = ctrl_q.sub_op;
  assign inv_a  = ctrl_q.inv_a;
  assign inv_b  = ctrl_q.inv_b;
  assign cin    = ctrl_q.cin;
  assign b_sel  = ctrl_q.b_sel;
  assign imm    = ctrl_q.imm;
  assign rs     = ctrl_q.rs;
  assign rt     = ctrl_q.rt;
  assign wr_en  = ctrl_q.wr_en;
  assign wr_reg = ctrl_q.wr_reg;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Scoreboard bench for alu_ctrl_decode: directed instructions with
// hand-computed control bundles, plus stall, flush, siic and HALT cases.
module tb_alu_ctrl_decode;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [1:0]  sub_op;
    logic        inv_a;
    logic        inv_b;
    logic        cin;
    logic [1:0]  b_sel;
    logic [15:0] imm;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic        exc;
  } exp_t;

  typedef struct packed {
    logic [15:0] instr;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_op;
  logic [1:0]  sub_op;
  logic        inv_a;
  logic        inv_b;
  logic        cin;
  logic [1:0]  b_sel;
  logic [15:0] imm;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic        exc;
  logic        halted;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  alu_ctrl_decode dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_op   (alu_op),
    .sub_op   (sub_op),
    .inv_a    (inv_a),
    .inv_b    (inv_b),
    .cin      (cin),
    .b_sel    (b_sel),
    .imm      (imm),
    .rs       (rs),
    .rt       (rt),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .exc      (exc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ins, input logic [4:0] op, input logic [1:0] sop,
                              input logic ia, input logic ib, input logic ci, input logic [1:0] bs,
                              input logic [15:0] im, input logic we, input logic [2:0] wr, input logic ex);
    vec_t v;
    v.instr = ins;
    v.e = '{alu_op: op, sub_op: sop, inv_a: ia, inv_b: ib, cin: ci, b_sel: bs,
            imm: im, wr_en: we, wr_reg: wr, exc: ex};
    return v;
  endfunction

  // Accept is visible at the posedge; the expected bundle is queued then.
  task automatic applyStimulus(input logic [15:0] ins, input exp_t e, input bit deliver);
    bit got = 0;
    in_valid = 1'b1;
    instr    = ins;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    checkOutput("accept_in_time", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk);
      if (deliver) exp_q.push_back(e);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every EX transfer pops one expected bundle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("alu_op", 32'(alu_op), 32'(e.alu_op));
        checkOutput("sub_op", 32'(sub_op), 32'(e.sub_op));
        checkOutput("inv_a",  32'(inv_a),  32'(e.inv_a));
        checkOutput("inv_b",  32'(inv_b),  32'(e.inv_b));
        checkOutput("cin",    32'(cin),    32'(e.cin));
        checkOutput("b_sel",  32'(b_sel),  32'(e.b_sel));
        checkOutput("imm",    32'(imm),    32'(e.imm));
        checkOutput("wr_en",  32'(wr_en),  32'(e.wr_en));
        if (e.wr_en) checkOutput("wr_reg", 32'(wr_reg), 32'(e.wr_reg));
        checkOutput("exc",    32'(exc),    32'(e.exc));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    vecs.push_back(mk(16'h423F, 5'b01000, 2'b00, 0, 0, 0, 2'b01, 16'hFFFF, 1, 3'd1, 0));
    vecs.push_back(mk(16'hD94D, 5'b11011, 2'b01, 1, 0, 1, 2'b00, 16'h0000, 1, 3'd3, 0));
    vecs.push_back(mk(16'h5A25, 5'b01011, 2'b00, 0, 1, 0, 2'b01, 16'h0005, 1, 3'd1, 0));
    vecs.push_back(mk(16'hE94C, 5'b11101, 2'b00, 0, 1, 1, 2'b00, 16'h0000, 1, 3'd3, 0));
    vecs.push_back(mk(16'hE14C, 5'b11100, 2'b00, 0, 1, 1, 2'b00, 16'h0000, 1, 3'd3, 0));
    vecs.push_back(mk(16'h61FE, 5'b01100, 2'b00, 0, 0, 0, 2'b10, 16'hFFFE, 0, 3'd0, 0));
    vecs.push_back(mk(16'h3400, 5'b00110, 2'b00, 0, 0, 0, 2'b01, 16'hFC00, 1, 3'd7, 0));
    vecs.push_back(mk(16'h39FF, 5'b00111, 2'b00, 0, 0, 0, 2'b01, 16'hFFFF, 1, 3'd7, 0));
    vecs.push_back(mk(16'hC580, 5'b11000, 2'b00, 0, 0, 0, 2'b01, 16'hFF80, 1, 3'd5, 0));
    vecs.push_back(mk(16'h9280, 5'b10010, 2'b00, 0, 0, 0, 2'b01, 16'h0080, 1, 3'd2, 0));
    vecs.push_back(mk(16'h523F, 5'b01010, 2'b00, 0, 0, 0, 2'b01, 16'h001F, 1, 3'd1, 0));
    vecs.push_back(mk(16'h8230, 5'b10000, 2'b00, 0, 0, 0, 2'b01, 16'hFFF0, 0, 3'd0, 0));
    vecs.push_back(mk(16'h4A21, 5'b01001, 2'b00, 1, 0, 1, 2'b01, 16'h0001, 1, 3'd1, 0));
    vecs.push_back(mk(16'hD94F, 5'b11011, 2'b11, 0, 1, 0, 2'b00, 16'h0000, 1, 3'd3, 0));
    vecs.push_back(mk(16'hC90C, 5'b11001, 2'b00, 0, 0, 0, 2'b10, 16'h0000, 1, 3'd3, 0));
    vecs.push_back(mk(16'hA230, 5'b10100, 2'b00, 0, 0, 0, 2'b01, 16'h0010, 1, 3'd1, 0));
    vecs.push_back(mk(16'h1000, 5'b00010, 2'b00, 0, 0, 0, 2'b01, 16'h0000, 0, 3'd0, 1));

    rst = 1'b1; in_valid = 1'b0; instr = 16'h0000; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_halted",    32'(halted),    32'd0);
    checkOutput("rst_exc",       32'(exc),       32'd0);
    checkOutput("rst_wr_en",     32'(wr_en),     32'd0);
    checkOutput("rst_alu_op",    32'(alu_op),    32'h01);
    checkOutput("rst_imm",       32'(imm),       32'd0);
    checkOutput("rst_b_sel",     32'(b_sel),     32'd0);
    checkOutput("rst_ctrl_bits", 32'({inv_a, inv_b, cin, sub_op}), 32'd0);
    checkOutput("rst_regs",      32'({rs, rt, wr_reg}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v.instr, v.e, 1'b1);
    end

    // siic pulse lasts exactly one cycle.
    idle(2);
    v = vecs[16];
    applyStimulus(16'h1000, v.e, 1'b1);
    @(negedge clk);
    checkOutput("siic_exc_set",   32'(exc),       32'd1);
    checkOutput("siic_valid",     32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("siic_exc_clear", 32'(exc),       32'd0);

    // Stall for three cycles with a second beat waiting.
    idle(2);
    out_ready = 1'b0;
    v = vecs[0];
    applyStimulus(16'h423F, v.e, 1'b1);
    in_valid = 1'b1; instr = 16'hD94D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_valid",    32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready),  32'd0);
      checkOutput("stall_imm",      32'(imm),       32'hFFFF);
      checkOutput("stall_alu_op",   32'(alu_op),    32'h08);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("unstall_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    v = vecs[1];
    exp_q.push_back(v.e);
    #1; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("unstall_next_op", 32'(alu_op), 32'h1B);

    // Flush together with an incoming beat while a bundle is presented.
    idle(2);
    v = vecs[10];
    applyStimulus(16'h523F, v.e, 1'b1);
    in_valid = 1'b1; instr = 16'h4A21; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_wr_en", 32'(wr_en),     32'd0);

    // Flush during a stall.
    idle(2);
    out_ready = 1'b0;
    v = vecs[11];
    applyStimulus(16'h8230, v.e, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("stall_flush_pre", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("stall_flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // Squashed siic and HALT must leave no trace.
    idle(2);
    in_valid = 1'b1; instr = 16'h1000; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("siic_flush_exc",   32'(exc),       32'd0);
    checkOutput("siic_flush_valid", 32'(out_valid), 32'd0);
    idle(1);
    in_valid = 1'b1; instr = 16'h0000; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("halt_flush_halted", 32'(halted),   32'd0);
    checkOutput("halt_flush_ready",  32'(in_ready), 32'd1);

    // HALT sticks until reset, even with EX ready.
    idle(2);
    v = mk(16'h0000, 5'b00000, 2'b00, 0, 0, 0, 2'b01, 16'h0000, 0, 3'd0, 0);
    applyStimulus(16'h0000, v.e, 1'b1);
    in_valid = 1'b1; instr = 16'h423F;
    @(negedge clk);
    checkOutput("halt_set",      32'(halted),   32'd1);
    checkOutput("halt_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("halt_hold_ready",  32'(in_ready),  32'd0);
      checkOutput("halt_hold_valid",  32'(out_valid), 32'd0);
      checkOutput("halt_hold_halted", 32'(halted),    32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_halted", 32'(halted),    32'd0);
    checkOutput("post_rst_valid",  32'(out_valid), 32'd0);
    checkOutput("post_rst_ready",  32'(in_ready),  32'd1);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
